wfa_reduce_sched: RTL and testbench

//  Per-score scheduler for the wavefront-reduction datapath. Accepts one (Kmin,Kmax) per score step

---
 rtl/wfa_reduce_sched_if.sv | 37 +++
 rtl/wfa_reduce_sched.sv | 195 +++++++++++++++++++
 tb/tb_wfa_reduce_sched.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wfa_reduce_sched_if.sv
// Handshake bundle for wfa_reduce_sched: score-step input, reducer start/done and final-bounds output.
// slave = scheduler side, master = score controller / reducer / consumer side.
interface wfa_reduce_sched_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  step_valid;
    logic                  step_ready;
    logic [DATA_WIDTH-1:0] step_kmin;
    logic [DATA_WIDTH-1:0] step_kmax;
    logic                  red_start;
    logic                  red_done;
    logic [DATA_WIDTH-1:0] red_kmin_new;
    logic [DATA_WIDTH-1:0] red_kmax_new;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_kmin;
    logic [DATA_WIDTH-1:0] out_kmax;
    logic                  out_reduced;
    logic                  err_timeout;
    logic [15:0]           reduce_count;

    modport slave (
        input  step_valid, step_kmin, step_kmax,
        input  red_done, red_kmin_new, red_kmax_new,
        input  out_ready,
        output step_ready, red_start,
        output out_valid, out_kmin, out_kmax, out_reduced, err_timeout, reduce_count
    );

    modport master (
        output step_valid, step_kmin, step_kmax,
        output red_done, red_kmin_new, red_kmax_new,
        output out_ready,
        input  step_ready, red_start,
        input  out_valid, out_kmin, out_kmax, out_reduced, err_timeout, reduce_count
    );
endinterface

// File: rtl/wfa_reduce_sched.sv
// Per-score wavefront-reduction scheduler: decides per step whether to reduce, drives the reducer, clamps results.
// Optional WFA_REDUCE_SCHED_STATS_EN: implements the saturating reduce_count statistic (tied to 0 otherwise).
module wfa_reduce_sched #(
    parameter int DATA_WIDTH      = 8,
    parameter int REDUCE_INTERVAL = 4,
    parameter int MIN_WF_LEN      = 10,
    parameter int TIMEOUT         = 64
) (
    input logic               clk,
    input logic               rst,
    wfa_reduce_sched_if.slave bus
);
    localparam int CW  = (REDUCE_INTERVAL > 1) ? $clog2(REDUCE_INTERVAL) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int DW1 = DATA_WIDTH + 1;
    localparam logic [CW-1:0]         CNT_LAST = CW'(REDUCE_INTERVAL - 1);
    localparam logic [TW-1:0]         TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic signed [DW1-1:0] MIN_LEN  = DW1'(MIN_WF_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_CLAMP,
        S_OUT
    } state_t;

    state_t                        state_q, state_d;
    logic                          step_ready_q, step_ready_d;
    logic                          red_start_q, red_start_d;
    logic                          out_valid_q, out_valid_d;
    logic                          out_reduced_q, out_reduced_d;
    logic                          err_timeout_q, err_timeout_d;
    logic signed [DATA_WIDTH-1:0]  out_kmin_q, out_kmin_d;
    logic signed [DATA_WIDTH-1:0]  out_kmax_q, out_kmax_d;
    logic signed [DATA_WIDTH-1:0]  kmin_q, kmin_d;
    logic signed [DATA_WIDTH-1:0]  kmax_q, kmax_d;
    logic signed [DATA_WIDTH-1:0]  rkmin_q, rkmin_d;
    logic signed [DATA_WIDTH-1:0]  rkmax_q, rkmax_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [TW-1:0]                 timer_q, timer_d;
`ifdef WFA_REDUCE_SCHED_STATS_EN
    logic [15:0]                   reduce_count_q, reduce_count_d;
`endif

    logic signed [DW1-1:0]         width;
    logic signed [DATA_WIDTH-1:0]  nkmin, nkmax;

    always_comb begin
        // Width is formed one bit wider than the bounds so kmax-kmin+1 does not wrap for normal ranges.
        width = {kmax_q[DATA_WIDTH-1], kmax_q} - {kmin_q[DATA_WIDTH-1], kmin_q} + DW1'(1);
        nkmin = (rkmin_q > kmin_q) ? rkmin_q : kmin_q;
        nkmax = (rkmax_q < kmax_q) ? rkmax_q : kmax_q;

        state_d       = state_q;
        red_start_d   = 1'b0;
        out_valid_d   = out_valid_q;
        out_reduced_d = out_reduced_q;
        err_timeout_d = err_timeout_q;
        out_kmin_d    = out_kmin_q;
        out_kmax_d    = out_kmax_q;
        kmin_d        = kmin_q;
        kmax_d        = kmax_q;
        rkmin_d       = rkmin_q;
        rkmax_d       = rkmax_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
`ifdef WFA_REDUCE_SCHED_STATS_EN
        reduce_count_d = reduce_count_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (step_ready_q && bus.step_valid) begin
                    kmin_d  = bus.step_kmin;
                    kmax_d  = bus.step_kmax;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cnt_q == CNT_LAST && width >= MIN_LEN) begin
                    cnt_d       = '0;
                    red_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end else begin
                    cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
                    out_kmin_d    = kmin_q;
                    out_kmax_d    = kmax_q;
                    out_reduced_d = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = S_OUT;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.red_done) begin
                    rkmin_d = bus.red_kmin_new;
                    rkmax_d = bus.red_kmax_new;
                    state_d = S_CLAMP;
                end else if (timer_q == TMR_LAST) begin
                    err_timeout_d = 1'b1;
                    out_kmin_d    = kmin_q;
                    out_kmax_d    = kmax_q;
                    out_reduced_d = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = S_OUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CLAMP: begin
                out_valid_d = 1'b1;
                state_d     = S_OUT;
                if (nkmin > nkmax) begin
                    out_kmin_d    = kmin_q;
                    out_kmax_d    = kmax_q;
                    out_reduced_d = 1'b0;
                end else begin
                    out_kmin_d    = nkmin;
                    out_kmax_d    = nkmax;
                    out_reduced_d = 1'b1;
`ifdef WFA_REDUCE_SCHED_STATS_EN
                    if (reduce_count_q != 16'hFFFF) reduce_count_d = reduce_count_q + 16'd1;
`endif
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        step_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            step_ready_q  <= 1'b0;
            red_start_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_reduced_q <= 1'b0;
            err_timeout_q <= 1'b0;
            out_kmin_q    <= '0;
            out_kmax_q    <= '0;
            kmin_q        <= '0;
            kmax_q        <= '0;
            rkmin_q       <= '0;
            rkmax_q       <= '0;
            cnt_q         <= '0;
            timer_q       <= '0;
`ifdef WFA_REDUCE_SCHED_STATS_EN
            reduce_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            step_ready_q  <= step_ready_d;
            red_start_q   <= red_start_d;
            out_valid_q   <= out_valid_d;
            out_reduced_q <= out_reduced_d;
            err_timeout_q <= err_timeout_d;
            out_kmin_q    <= out_kmin_d;
            out_kmax_q    <= out_kmax_d;
            kmin_q        <= kmin_d;
            kmax_q        <= kmax_d;
            rkmin_q       <= rkmin_d;
            rkmax_q       <= rkmax_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
`ifdef WFA_REDUCE_SCHED_STATS_EN
            reduce_count_q <= reduce_count_d;
`endif
        end
    end

    assign bus.step_ready  = step_ready_q;
    assign bus.red_start   = red_start_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_kmin    = out_kmin_q;
    assign bus.out_kmax    = out_kmax_q;
    assign bus.out_reduced = out_reduced_q;
    assign bus.err_timeout = err_timeout_q;
`ifdef WFA_REDUCE_SCHED_STATS_EN
    assign bus.reduce_count = reduce_count_q;
`else
    assign bus.reduce_count = '0;
`endif
endmodule

// File: tb/tb_wfa_reduce_sched.sv
// Randomized bench for wfa_reduce_sched with a transaction-level reference model and reducer responder.
module tb_wfa_reduce_sched;
    localparam int DW   = 8;
    localparam int RI   = 4;
    localparam int MINW = 10;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wfa_reduce_sched_if #(.DATA_WIDTH(DW)) bus ();

    wfa_reduce_sched #(
        .DATA_WIDTH(DW),
        .REDUCE_INTERVAL(RI),
        .MIN_WF_LEN(MINW),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: position within the reduce interval, sticky error, accepted reductions.
    int m_icnt  = 0;
    int m_err   = 0;
    int m_count = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int exp_count();
`ifdef WFA_REDUCE_SCHED_STATS_EN
        return m_count;
`else
        return 0;
`endif
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.step_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.step_ready !== 1'b1) check("ready_wait", 0, 1);
    endtask

    // One full step transaction. mode 0: reducer answers after lat WAIT cycles; mode 1: never answers.
    task automatic run_step(input int kmin, input int kmax, input int mode, input int lat,
                            input int rkmin, input int rkmax, input int hold, input int spur);
        int w, lo, hi, exp_lo, exp_hi, exp_red, n;
        bit attempt;
        wait_ready();
        w       = kmax - kmin + 1;
        attempt = (m_icnt == RI - 1) && (w >= MINW);
        m_icnt  = attempt ? 0 : (m_icnt + 1) % RI;
        exp_lo  = kmin;
        exp_hi  = kmax;
        exp_red = 0;
        if (attempt) begin
            if (mode == 1) begin
                m_err = 1;
            end else begin
                lo = (rkmin > kmin) ? rkmin : kmin;
                hi = (rkmax < kmax) ? rkmax : kmax;
                if (lo <= hi) begin
                    exp_lo  = lo;
                    exp_hi  = hi;
                    exp_red = 1;
                    if (m_count < 65535) m_count++;
                end
            end
        end

        bus.step_valid = 1'b1;
        bus.step_kmin  = DW'(kmin);
        bus.step_kmax  = DW'(kmax);
        @(negedge clk);
        bus.step_valid = 1'b0;
        bus.step_kmin  = DW'($urandom);
        bus.step_kmax  = DW'($urandom);
        check("ready_busy", int'(bus.step_ready), 0);
        check("out_early", int'(bus.out_valid), 0);
        @(negedge clk);
        check("start", int'(bus.red_start), int'(attempt));
        if (attempt) begin
            if (spur != 0) begin
                bus.red_done     = 1'b1;
                bus.red_kmin_new = DW'($urandom);
                bus.red_kmax_new = DW'($urandom);
            end
            @(negedge clk);
            bus.red_done = 1'b0;
            check("start_pulse", int'(bus.red_start), 0);
            if (mode == 0) begin
                repeat (lat) @(negedge clk);
                bus.red_done     = 1'b1;
                bus.red_kmin_new = DW'(rkmin);
                bus.red_kmax_new = DW'(rkmax);
                @(negedge clk);
                bus.red_done = 1'b0;
                check("out_clamp_early", int'(bus.out_valid), 0);
                @(negedge clk);
            end else begin
                n = 0;
                while (bus.out_valid !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("timeout_lat", n, TMO);
            end
        end

        check("out_valid", int'(bus.out_valid), 1);
        check("out_kmin", sx(bus.out_kmin), exp_lo);
        check("out_kmax", sx(bus.out_kmax), exp_hi);
        check("out_reduced", int'(bus.out_reduced), exp_red);
        check("err_timeout", int'(bus.err_timeout), m_err);
        check("reduce_count", int'(bus.reduce_count), exp_count());
        for (int i = 0; i < hold; i++) begin
            bus.out_ready = 1'b0;
            if (spur != 0 && i == 0) begin
                bus.red_done     = 1'b1;
                bus.red_kmin_new = DW'($urandom);
                bus.red_kmax_new = DW'($urandom);
            end
            @(negedge clk);
            bus.red_done = 1'b0;
            check("hold_valid", int'(bus.out_valid), 1);
            check("hold_kmin", sx(bus.out_kmin), exp_lo);
            check("hold_kmax", sx(bus.out_kmax), exp_hi);
            check("hold_reduced", int'(bus.out_reduced), exp_red);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_drop", int'(bus.out_valid), 0);
        check("ready_back", int'(bus.step_ready), 1);
    endtask

    task automatic to_slot();
        while (m_icnt != RI - 1) run_step(0, 30, 0, 0, 0, 30, 0, 0);
    endtask

    task automatic reset_abort();
        to_slot();
        wait_ready();
        bus.step_valid = 1'b1;
        bus.step_kmin  = DW'(0);
        bus.step_kmax  = DW'(30);
        @(negedge clk);
        bus.step_valid = 1'b0;
        @(negedge clk);
        check("rst_case_start", int'(bus.red_start), 1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready_low", int'(bus.step_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_err", int'(bus.err_timeout), 0);
        check("rst_count", int'(bus.reduce_count), 0);
        rst = 1'b0;
        bus.red_done     = 1'b1;
        bus.red_kmin_new = DW'(5);
        bus.red_kmax_new = DW'(10);
        @(negedge clk);
        bus.red_done = 1'b0;
        check("rst_ready_high", int'(bus.step_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("late_done_out", int'(bus.out_valid), 0);
            check("late_done_start", int'(bus.red_start), 0);
        end
        m_icnt  = 0;
        m_err   = 0;
        m_count = 0;
    endtask

    initial begin
        int kmin, kmax;
        rst              = 1'b1;
        bus.step_valid   = 1'b0;
        bus.step_kmin    = '0;
        bus.step_kmax    = '0;
        bus.red_done     = 1'b0;
        bus.red_kmin_new = '0;
        bus.red_kmax_new = '0;
        bus.out_ready    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", int'(bus.step_ready), 0);
        check("reset_valid", int'(bus.out_valid), 0);
        check("reset_start", int'(bus.red_start), 0);
        check("reset_err", int'(bus.err_timeout), 0);
        check("reset_kmin", sx(bus.out_kmin), 0);
        check("reset_kmax", sx(bus.out_kmax), 0);
        check("reset_reduced", int'(bus.out_reduced), 0);
        check("reset_count", int'(bus.reduce_count), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", int'(bus.step_ready), 1);

        // Four equal steps: only the fourth reduces.
        for (int i = 0; i < 4; i++) run_step(0, 30, 0, 2, -9, 40, 1, 0);
        to_slot(); run_step(-5, 20, 0, 3, -9, 40, 0, 1);
        to_slot(); run_step(-5, 20, 0, 1, 12, 3, 2, 0);
        to_slot(); run_step(-5, 20, 0, 7, -2, 15, 0, 0);
        to_slot(); run_step(-2, 3, 0, 0, 0, 0, 0, 0);
        run_step(0, 30, 0, 0, 0, 30, 0, 0);
        to_slot(); run_step(0, 8, 0, 0, 2, 6, 0, 0);
        to_slot(); run_step(0, 9, 0, 0, 2, 6, 0, 0);
        to_slot(); run_step(-5, 20, 0, TMO - 1, -3, 18, 0, 0);
        to_slot(); run_step(-5, 20, 1, 0, 0, 0, 1, 0);
        run_step(1, 2, 0, 0, 0, 0, 0, 0);
        reset_abort();

        for (int t = 0; t < 60; t++) begin
            kmin = int'($urandom_range(0, 100)) - 60;
            kmax = kmin + int'($urandom_range(0, 40)) - 3;
            run_step(kmin, kmax, ($urandom_range(0, 9) == 0) ? 1 : 0, int'($urandom_range(0, 20)),
                     kmin + int'($urandom_range(0, 30)) - 10, kmax - int'($urandom_range(0, 30)) + 10,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit reached");
    end
endmodule
